// File: rtl/wshb_pkg.sv
// Shared Wishbone B4 definitions for the on-chip video RAM slave:
// cycle-type / burst-type encodings and the slave state type.
package wshb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    BURST
  } wshb_slv_state_t;

endpackage

// File: rtl/wshb_burst_addr.sv
// Next word address of an incrementing burst. Linear bursts add one word
// and wrap modulo the memory depth; wrap-N bursts increment only the low
// log2(N) bits and keep the upper bits. lin_ovf flags a linear step off
// the last word of the memory.
import wshb_pkg::*;

module wshb_burst_addr #(
  parameter int MEM_AW = 10
) (
  input  logic [MEM_AW-1:0] addr,
  input  logic [1:0]        bte,
  output logic [MEM_AW-1:0] next_addr,
  output logic              lin_ovf
);

  logic [MEM_AW-1:0] inc;
  logic [MEM_AW-1:0] mask;

  // Select which address bits take part in the increment
  always_comb begin
    inc     = addr + MEM_AW'(1);
    mask    = '1;
    lin_ovf = 1'b0;
    case (bte)
      BTE_WRAP4:  mask = MEM_AW'(3);
      BTE_WRAP8:  mask = MEM_AW'(7);
      BTE_WRAP16: mask = MEM_AW'(15);
      default:    lin_ovf = &addr;
    endcase
    next_addr = (addr & ~mask) | (inc & mask);
  end

endmodule

// File: rtl/wshb_slave_mem.sv
// Wishbone B4 registered-feedback slave in front of a 32-bit word RAM.
// Serves classic cycles and incrementing bursts (linear, wrap-4/8/16)
// with WAIT_STATES extra cycles before the first acknowledge.
// Every acknowledged beat is issued at the clock edge that raises ack:
// the write is committed and the read word registered on that same edge.
// Build option WSHB_MEM_ERR_EN: out-of-range addresses and linear bursts
// running off the end of memory terminate with err instead of ack.
import wshb_pkg::*;

module wshb_slave_mem #(
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_ms,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty
);

  localparam logic [3:0] WCNT_LAST = 4'(WAIT_STATES - 1);

  wshb_slv_state_t   state;
  logic [3:0]        wcnt_q;
  logic              term_q;
  logic [MEM_AW-1:0] addr_q;
  logic [1:0]        bte_q;

  logic [31:0]       mem [2**MEM_AW];

  logic              start;
  logic              issue;
  logic              beat_err;
  logic              wr_en;
  logic              rd_en;
  logic [MEM_AW-1:0] adr_word;
  logic [MEM_AW-1:0] beat_addr;
  logic [1:0]        beat_bte;
  logic [MEM_AW-1:0] addr_nxt;
  logic              lin_ovf;
  logic              unused_bits;

`ifdef WSHB_MEM_ERR_EN
  logic              err_q;
  logic              upper_bad;
  assign upper_bad   = |adr[31:MEM_AW+2];
  assign unused_bits = ^adr[1:0];
`else
  assign unused_bits = ^{adr[1:0], adr[31:MEM_AW+2], lin_ovf};
`endif

  assign rty      = 1'b0;
  assign adr_word = adr[MEM_AW+1:2];
  assign start    = (state == IDLE) & cyc & stb;

  // In IDLE the beat uses the live bus address; afterwards the counter
  assign beat_addr = (state == IDLE) ? adr_word : addr_q;
  assign beat_bte  = (state == IDLE) ? ((cti == CTI_INCR) ? bte : BTE_LINEAR) : bte_q;

  wshb_burst_addr #(.MEM_AW(MEM_AW)) u_burst_addr (
    .addr      (beat_addr),
    .bte       (beat_bte),
    .next_addr (addr_nxt),
    .lin_ovf   (lin_ovf)
  );

  // Decide whether a beat is issued (acked or errored) at this edge
  always_comb begin
    issue = 1'b0;
    case (state)
      IDLE:       issue = cyc & stb & (WAIT_STATES == 0);
      WAIT:       issue = cyc & stb & (wcnt_q == WCNT_LAST);
      ACK, BURST: issue = cyc & stb & ~term_q;
      default:    issue = 1'b0;
    endcase
  end

`ifdef WSHB_MEM_ERR_EN
  assign beat_err = (state == IDLE) ? upper_bad : err_q;
`else
  assign beat_err = 1'b0;
`endif

  assign wr_en = issue & we & ~beat_err & ~rst;
  assign rd_en = issue & ~we & ~beat_err;

  // Bus FSM with registered ack/err; reset abandons any open cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wcnt_q <= 4'd0;
      term_q <= 1'b1;
      ack    <= 1'b0;
      err    <= 1'b0;
`ifdef WSHB_MEM_ERR_EN
      err_q  <= 1'b0;
`endif
    end else begin
      ack <= issue & ~beat_err;
      err <= issue & beat_err;
      case (state)
        IDLE: begin
          if (cyc && stb) begin
            term_q <= (cti != CTI_INCR);
            wcnt_q <= 4'd0;
`ifdef WSHB_MEM_ERR_EN
            err_q  <= upper_bad;
`endif
            state  <= (WAIT_STATES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!cyc) begin
            state <= IDLE;
          end else if (issue) begin
            state <= ACK;
          end else if (wcnt_q != WCNT_LAST) begin
            wcnt_q <= wcnt_q + 4'd1;
          end
        end
        ACK, BURST: begin
          if (!cyc || term_q) begin
            state <= IDLE;
          end else if (stb) begin
            state  <= BURST;
            term_q <= (cti != CTI_INCR);
          end
        end
        default: state <= IDLE;
      endcase
`ifdef WSHB_MEM_ERR_EN
      // Once a linear burst steps past the last word, all later beats error
      if (issue && lin_ovf) begin
        err_q <= 1'b1;
      end
`endif
    end
  end

  // Address counter: loaded at cycle start, advanced on each issued beat
  always_ff @(posedge clk) begin
    if (start) begin
      addr_q <= issue ? addr_nxt : adr_word;
      bte_q  <= beat_bte;
    end else if (issue) begin
      addr_q <= addr_nxt;
    end
  end

  // Byte-enabled RAM write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          mem[beat_addr][8*i +: 8] <= dat_ms[8*i +: 8];
        end
      end
    end
  end

  // Registered read word; holds between read beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_sm <= 32'd0;
    end else if (rd_en) begin
      dat_sm <= mem[beat_addr];
    end
  end

endmodule

// File: tb/tb_wshb_slave_mem.sv
// Testbench for wshb_slave_mem: a per-cycle vector table on a zero-wait
// instance, plus hand-written wait-state and reset sequences on a
// WAIT_STATES=3 instance sharing the same bus inputs.
module tb_wshb_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat0, dat3;
  logic        ack0, err0, rty0, ack3, err3, rty3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wshb_slave_mem #(.MEM_AW(10), .WAIT_STATES(0)) u_dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .dat_ms(dat_ms), .cti(cti), .bte(bte), .dat_sm(dat0), .ack(ack0), .err(err0), .rty(rty0)
  );

  wshb_slave_mem #(.MEM_AW(10), .WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .dat_ms(dat_ms), .cti(cti), .bte(bte), .dat_sm(dat3), .ack(ack3), .err(err3), .rty(rty3)
  );

  typedef struct {
    logic        c, s, w;
    logic [31:0] a, d;
    logic [3:0]  sl;
    logic [2:0]  ct;
    logic [1:0]  bt;
    logic        ea, ee, cd;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, s, w, input logic [31:0] a, d,
                              input logic [3:0] sl, input logic [2:0] ct, input logic [1:0] bt,
                              input logic ea, ee, cd, input logic [31:0] ed);
    vec_t v;
    v.c = c; v.s = s; v.w = w; v.a = a; v.d = d; v.sl = sl; v.ct = ct; v.bt = bt;
    v.ea = ea; v.ee = ee; v.cd = cd; v.ed = ed;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, s, w, input logic [31:0] a, d, input logic [3:0] sl,
                       input logic [2:0] ct, input logic [1:0] bt);
    cyc = c; stb = s; we = w; adr = a; dat_ms = d; sel = sl; cti = ct; bte = bt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
  endtask

  // Four-cycle classic access on the WAIT_STATES=3 instance, checking ack timing
  task automatic ws3_classic(input string nm, input logic w, input logic [31:0] a, d,
                             input logic chk_d, input logic [31:0] exp_d);
    drive(1, 1, w, a, d, 4'hF, 3'b000, 2'b00);
    for (int t = 1; t <= 4; t++) begin
      tick();
      check($sformatf("%s ack t%0d", nm, t), 32'(ack3), 32'(t == 4));
    end
    if (chk_d) check({nm, " dat"}, dat3, exp_d);
    tick();
    check({nm, " ack drop"}, 32'(ack3), 32'd0);
    idle();
    tick();
  endtask

  initial begin
    logic err_en;
`ifdef WSHB_MEM_ERR_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif

    // Classic write/read and byte-lane update
    vecs.push_back(mk(1,1,1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 1,0,0, 0));
    vecs.push_back(mk(1,1,1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(1,1,0, 32'h10, 0, 4'hF, 3'b000, 2'b00, 1,0,1, 32'hDEADBEEF));
    vecs.push_back(mk(1,1,0, 32'h10, 0, 4'hF, 3'b000, 2'b00, 0,0,1, 32'hDEADBEEF));
    vecs.push_back(mk(1,1,1, 32'h10, 32'h0000AB00, 4'b0010, 3'b000, 2'b00, 1,0,0, 0));
    vecs.push_back(mk(1,1,1, 32'h10, 32'h0000AB00, 4'b0010, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(1,1,0, 32'h10, 0, 4'hF, 3'b000, 2'b00, 1,0,1, 32'hDEADABEF));
    vecs.push_back(mk(1,1,0, 32'h10, 0, 4'hF, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));
    // Linear write burst filling mem[i]=i, i=0..3
    vecs.push_back(mk(1,1,1, 32'h0, 32'd0, 4'hF, 3'b010, 2'b00, 1,0,0, 0));
    vecs.push_back(mk(1,1,1, 32'h4, 32'd1, 4'hF, 3'b010, 2'b00, 1,0,0, 0));
    vecs.push_back(mk(1,1,1, 32'h8, 32'd2, 4'hF, 3'b010, 2'b00, 1,0,0, 0));
    vecs.push_back(mk(1,1,1, 32'hC, 32'd3, 4'hF, 3'b111, 2'b00, 1,0,0, 0));
    vecs.push_back(mk(1,1,1, 32'hC, 32'd3, 4'hF, 3'b111, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));
    // Linear read burst from 0
    vecs.push_back(mk(1,1,0, 32'h0, 0, 4'hF, 3'b010, 2'b00, 1,0,1, 32'd0));
    vecs.push_back(mk(1,1,0, 32'h0, 0, 4'hF, 3'b010, 2'b00, 1,0,1, 32'd1));
    vecs.push_back(mk(1,1,0, 32'h0, 0, 4'hF, 3'b010, 2'b00, 1,0,1, 32'd2));
    vecs.push_back(mk(1,1,0, 32'h0, 0, 4'hF, 3'b111, 2'b00, 1,0,1, 32'd3));
    vecs.push_back(mk(1,1,0, 32'h0, 0, 4'hF, 3'b111, 2'b00, 0,0,1, 32'd3));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));
    // Wrap-4 read burst from word 2 with a two-cycle stb gap
    vecs.push_back(mk(1,1,0, 32'h8, 0, 4'hF, 3'b010, 2'b01, 1,0,1, 32'd2));
    vecs.push_back(mk(1,1,0, 32'h8, 0, 4'hF, 3'b010, 2'b01, 1,0,1, 32'd3));
    vecs.push_back(mk(1,0,0, 32'h8, 0, 4'hF, 3'b010, 2'b01, 0,0,1, 32'd3));
    vecs.push_back(mk(1,0,0, 32'h8, 0, 4'hF, 3'b010, 2'b01, 0,0,1, 32'd3));
    vecs.push_back(mk(1,1,0, 32'h8, 0, 4'hF, 3'b010, 2'b01, 1,0,1, 32'd0));
    vecs.push_back(mk(1,1,0, 32'h8, 0, 4'hF, 3'b111, 2'b01, 1,0,1, 32'd1));
    vecs.push_back(mk(1,1,0, 32'h8, 0, 4'hF, 3'b111, 2'b01, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));
    // Last word, then a linear burst stepping past it
    vecs.push_back(mk(1,1,1, 32'hFFC, 32'hCAFEF00D, 4'hF, 3'b000, 2'b00, 1,0,0, 0));
    vecs.push_back(mk(1,1,1, 32'hFFC, 32'hCAFEF00D, 4'hF, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(1,1,0, 32'hFFC, 0, 4'hF, 3'b010, 2'b00, 1,0,1, 32'hCAFEF00D));
    vecs.push_back(mk(1,1,0, 32'hFFC, 0, 4'hF, 3'b111, 2'b00, ~err_en, err_en, 1,
                      err_en ? 32'hCAFEF00D : 32'd0));
    vecs.push_back(mk(1,1,0, 32'hFFC, 0, 4'hF, 3'b111, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));
    // Out-of-range write: aliases to word 0, or errors with the option built in
    vecs.push_back(mk(1,1,1, 32'h1000, 32'h12345678, 4'hF, 3'b000, 2'b00, ~err_en, err_en, 0, 0));
    vecs.push_back(mk(1,1,1, 32'h1000, 32'h12345678, 4'hF, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(1,1,0, 32'h0, 0, 4'hF, 3'b000, 2'b00, 1,0,1,
                      err_en ? 32'd0 : 32'h12345678));
    vecs.push_back(mk(1,1,0, 32'h0, 0, 4'hF, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));
    // cyc dropped mid-burst, then a fresh classic read
    vecs.push_back(mk(1,1,0, 32'h4, 0, 4'hF, 3'b010, 2'b00, 1,0,1, 32'd1));
    vecs.push_back(mk(0,0,0, 32'h4, 0, 4'hF, 3'b010, 2'b00, 0,0,1, 32'd1));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(1,1,0, 32'h8, 0, 4'hF, 3'b000, 2'b00, 1,0,1, 32'd2));
    vecs.push_back(mk(1,1,0, 32'h8, 0, 4'hF, 3'b000, 2'b00, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0, 0, 0, 3'b000, 2'b00, 0,0,0, 0));

    // Reset state
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset ack",  32'(ack0), 32'd0);
    check("reset err",  32'(err0), 32'd0);
    check("reset rty",  32'(rty0), 32'd0);
    check("reset dat",  dat0, 32'd0);
    check("reset ack3", 32'(ack3), 32'd0);
    check("reset rty3", 32'(rty3), 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].c, vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].sl, vecs[i].ct, vecs[i].bt);
      tick();
      check($sformatf("v%0d ack", i), 32'(ack0), 32'(vecs[i].ea));
      check($sformatf("v%0d err", i), 32'(err0), 32'(vecs[i].ee));
      if (vecs[i].cd) check($sformatf("v%0d dat", i), dat0, vecs[i].ed);
    end

    // Wait states: ack on the 4th edge after stb is first sampled
    ws3_classic("ws3 wr", 1'b1, 32'h40, 32'h5A5A5A5A, 1'b0, 32'h0);
    ws3_classic("ws3 rd", 1'b0, 32'h40, 32'h0, 1'b1, 32'h5A5A5A5A);

    // cyc dropped during WAIT: no ack, and the slave is idle again afterwards
    drive(1, 1, 0, 32'h40, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    tick();
    idle();
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("ws3 abort ack t%0d", t), 32'(ack3), 32'd0);
      check($sformatf("ws3 abort err t%0d", t), 32'(err3), 32'd0);
    end
    ws3_classic("ws3 after abort", 1'b0, 32'h40, 32'h0, 1'b1, 32'h5A5A5A5A);

    // Reset while a write waits: nothing acked, memory untouched
    ws3_classic("ws3 pre", 1'b1, 32'h50, 32'h11111111, 1'b0, 32'h0);
    drive(1, 1, 1, 32'h50, 32'h99999999, 4'hF, 3'b000, 2'b00);
    tick();
    tick();
    rst = 1'b1;
    #2;
    check("midrst ack3", 32'(ack3), 32'd0);
    check("midrst dat3", dat3, 32'd0);
    idle();
    tick();
    check("midrst ack3 held", 32'(ack3), 32'd0);
    rst = 1'b0;
    tick();
    ws3_classic("ws3 post rst", 1'b0, 32'h50, 32'h0, 1'b1, 32'h11111111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
